// File: rtl/alu_seq_pkg.sv
// Shared encodings for the single-button sequenced ALU: FSM states, MIPS funct
// opcodes and bit positions inside the {N,Z,C,V} flag vector.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RES = 2'b11
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a single-cycle
// pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_d_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level, so any bounce back to the old level restarts it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync1_reg   <= i_btn;
            sync2_reg   <= sync1_reg;
            level_d_reg <= level_reg;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign o_pulse = level_reg & ~level_d_reg;

endmodule

// File: rtl/alu_seq_top.sv
// Sequenced ALU front end: one "next" button walks through A, B and opcode
// capture from the switches, then holds a registered result with NZCV flags.
module alu_seq_top
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int OP_WIDTH        = 6,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_sw,
    input  logic                  i_btn_next,
    input  logic                  i_btn_clr,
    output logic [DATA_WIDTH-1:0] o_led,
    output logic [3:0]            o_flags,
    output logic                  o_err,
    output logic [1:0]            o_state
);
    localparam int SH_W = $clog2(DATA_WIDTH);

    logic next_pulse;
    logic clr_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_next),
        .o_pulse (next_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_clr),
        .o_pulse (clr_pulse)
    );

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] a_reg, b_reg, led_reg;
    logic [OP_WIDTH-1:0]   op_reg;
    logic [3:0]            flags_reg;
    logic                  err_reg;
    logic                  load_a, load_b, load_res;

    // Clear has priority so a simultaneous next pulse is simply dropped.
    always_comb begin
        state_next = state_reg;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_res   = 1'b0;
        if (clr_pulse) begin
            state_next = S_A;
        end else if (next_pulse) begin
            case (state_reg)
                S_A:     begin load_a   = 1'b1; state_next = S_B;   end
                S_B:     begin load_b   = 1'b1; state_next = S_OP;  end
                S_OP:    begin load_res = 1'b1; state_next = S_RES; end
                default: state_next = S_A;
            endcase
        end
    end

    logic [OP_WIDTH-1:0]   op_sel;
    logic [DATA_WIDTH:0]   sum_ext, diff_ext;
    logic [SH_W-1:0]       sh_amt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_c, alu_v, alu_err;

    // The opcode is taken live from the switches on the capture edge.
    always_comb begin
        op_sel   = (state_reg == S_OP) ? i_sw[OP_WIDTH-1:0] : op_reg;
        sum_ext  = {1'b0, a_reg} + {1'b0, b_reg};
        diff_ext = {1'b0, a_reg} - {1'b0, b_reg};
        sh_amt   = b_reg[SH_W-1:0];
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_err  = 1'b0;
        case (op_sel)
            OP_WIDTH'(OP_ADD): begin
                alu_res = sum_ext[DATA_WIDTH-1:0];
                alu_c   = sum_ext[DATA_WIDTH];
                alu_v   = (a_reg[DATA_WIDTH-1] == b_reg[DATA_WIDTH-1]) &&
                          (alu_res[DATA_WIDTH-1] != a_reg[DATA_WIDTH-1]);
            end
            OP_WIDTH'(OP_SUB): begin
                alu_res = diff_ext[DATA_WIDTH-1:0];
                alu_c   = diff_ext[DATA_WIDTH];
                alu_v   = (a_reg[DATA_WIDTH-1] != b_reg[DATA_WIDTH-1]) &&
                          (alu_res[DATA_WIDTH-1] != a_reg[DATA_WIDTH-1]);
            end
            OP_WIDTH'(OP_AND): alu_res = a_reg & b_reg;
            OP_WIDTH'(OP_OR):  alu_res = a_reg | b_reg;
            OP_WIDTH'(OP_XOR): alu_res = a_reg ^ b_reg;
            OP_WIDTH'(OP_NOR): alu_res = ~(a_reg | b_reg);
            OP_WIDTH'(OP_SRL): alu_res = a_reg >> sh_amt;
            OP_WIDTH'(OP_SRA): alu_res = DATA_WIDTH'($signed(a_reg) >>> sh_amt);
            default:           alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= S_A;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            led_reg   <= '0;
            flags_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (clr_pulse) begin
                a_reg     <= '0;
                b_reg     <= '0;
                op_reg    <= '0;
                led_reg   <= '0;
                flags_reg <= '0;
                err_reg   <= 1'b0;
            end else begin
                if (load_a) a_reg <= i_sw;
                if (load_b) b_reg <= i_sw;
                if (load_res) begin
                    op_reg  <= i_sw[OP_WIDTH-1:0];
                    led_reg <= alu_res;
                    err_reg <= alu_err;
                    flags_reg[FLAG_N] <= !alu_err && alu_res[DATA_WIDTH-1];
                    flags_reg[FLAG_Z] <= !alu_err && (alu_res == '0);
                    flags_reg[FLAG_C] <= alu_c;
                    flags_reg[FLAG_V] <= alu_v;
                end
            end
        end
    end

    assign o_led   = led_reg;
    assign o_flags = flags_reg;
    assign o_err   = err_reg;
    assign o_state = state_reg;

endmodule

// File: tb/tb_alu_seq_top.sv
// Randomised bench for alu_seq_top with a cycle-level behavioural model and
// hand-computed spot checks.
module tb_alu_seq_top;
    localparam int DW = 8;
    localparam int OW = 6;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] sw = '0;
    logic          btn_next = 1'b0;
    logic          btn_clr = 1'b0;
    logic [DW-1:0] led;
    logic [3:0]    flags;
    logic          err;
    logic [1:0]    st;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq_top #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .DEBOUNCE_CYCLES(D)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sw       (sw),
        .i_btn_next (btn_next),
        .i_btn_clr  (btn_clr),
        .o_led      (led),
        .o_flags    (flags),
        .o_err      (err),
        .o_state    (st)
    );

    // ---------------- behavioural model ----------------
    logic [1:0]    m_state;
    logic [DW-1:0] m_a, m_b, m_led;
    logic [3:0]    m_flags;
    logic          m_err;
    logic          m_lvl_n, m_lvl_c, pend_n, pend_c;
    logic          hn[$];
    logic          hc[$];

    function automatic void ref_alu(input int a, input int b, input int op,
                                    output int r, output logic [3:0] f, output logic e);
        int sa, sb, sh;
        logic c, v;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        r = 0; c = 1'b0; v = 1'b0; e = 1'b0; f = 4'b0000;
        case (op)
            'h20: begin r = (a + b) % 256; c = (a + b) > 255;
                        v = (sa + sb > 127) || (sa + sb < -128); end
            'h22: begin r = (a - b + 256) % 256; c = a < b;
                        v = (sa - sb > 127) || (sa - sb < -128); end
            'h24: r = a & b;
            'h25: r = a | b;
            'h26: r = a ^ b;
            'h27: r = (~(a | b)) & 255;
            'h02: r = a >> sh;
            'h03: r = (sa >>> sh) & 255;
            default: e = 1'b1;
        endcase
        if (!e) f = {r >= 128, r == 0, c, v};
    endfunction

    // A level is accepted once D consecutive samples (seen through the
    // two-stage synchroniser) agree.
    function automatic logic next_level(input logic q[$], input logic lvl);
        for (int i = 1; i < D; i++) if (q[i] !== q[0]) return lvl;
        return q[0];
    endfunction

    task automatic model_reset();
        m_state = 2'b00; m_a = '0; m_b = '0; m_led = '0; m_flags = '0; m_err = 1'b0;
        m_lvl_n = 1'b0; m_lvl_c = 1'b0; pend_n = 1'b0; pend_c = 1'b0;
        hn = {}; hc = {};
        for (int i = 0; i <= D; i++) begin hn.push_back(1'b0); hc.push_back(1'b0); end
    endtask

    task automatic model_step();
        int r;
        logic [3:0] f;
        logic e, nl;
        if (pend_c) begin
            m_state = 2'b00; m_a = '0; m_b = '0; m_led = '0; m_flags = '0; m_err = 1'b0;
        end else if (pend_n) begin
            case (m_state)
                2'b00: begin m_a = sw; m_state = 2'b01; end
                2'b01: begin m_b = sw; m_state = 2'b10; end
                2'b10: begin
                    ref_alu(int'(m_a), int'(m_b), int'(sw[OW-1:0]), r, f, e);
                    m_led = DW'(r); m_flags = f; m_err = e; m_state = 2'b11;
                end
                default: m_state = 2'b00;
            endcase
        end
        nl = next_level(hn, m_lvl_n); pend_n = nl && !m_lvl_n; m_lvl_n = nl;
        nl = next_level(hc, m_lvl_c); pend_c = nl && !m_lvl_c; m_lvl_c = nl;
        hn.push_back(btn_next); void'(hn.pop_front());
        hc.push_back(btn_clr);  void'(hc.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            total++;
            if (st !== m_state || led !== m_led || flags !== m_flags || err !== m_err) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t: state=%0d led=%02h flags=%04b err=%0b, expected state=%0d led=%02h flags=%04b err=%0b",
                         $time, st, led, flags, err, m_state, m_led, m_flags, m_err);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic press(input logic [DW-1:0] v, input int hold);
        @(negedge clk);
        sw = v; btn_next = 1'b1;
        repeat (hold) @(negedge clk);
        btn_next = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic press_measure(input logic [DW-1:0] v, output int n);
        logic [1:0] old;
        @(negedge clk);
        sw = v; btn_next = 1'b1; old = st; n = 0;
        while (st == old && n < 20) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        btn_next = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic press_clr(input logic both);
        @(negedge clk);
        btn_clr = 1'b1; btn_next = both;
        repeat (8) @(negedge clk);
        btn_clr = 1'b0; btn_next = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] op);
        if (st == 2'b11) press(8'h00, 8);
        press(a, 8); press(b, 8); press(op, 8);
    endtask

    logic [DW-1:0] ops[9] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03, 8'h00};

    initial begin
        int n;
        logic [DW-1:0] op;
        // reset
        repeat (3) @(negedge clk);
        check("rst_led", led, 0); check("rst_flags", flags, 0);
        check("rst_err", err, 0); check("rst_state", st, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_state", st, 0); check("post_rst_led", led, 0);

        // basic add with latency measurement
        press_measure(8'd15, n); check("lat_a", n, 7);
        press_measure(8'd5, n);  check("lat_b", n, 7);
        press_measure(8'h20, n); check("lat_op", n, 7);
        check("add_led", led, 20); check("add_flags", flags, 4'b0000); check("add_state", st, 3);

        do_op(8'h7F, 8'h01, 8'h20);
        check("ovf_led", led, 8'h80); check("ovf_flags", flags, 4'b1001);
        do_op(8'd5, 8'd15, 8'h22);
        check("sub_led", led, 8'hF6); check("sub_flags", flags, 4'b1010);
        do_op(8'h80, 8'h01, 8'h03);
        check("sra_led", led, 8'hC0); check("sra_flags", flags, 4'b1000);
        do_op(8'h80, 8'h01, 8'h02);
        check("srl_led", led, 8'h40);
        do_op(8'hAA, 8'hAA, 8'h26);
        check("xor_led", led, 0); check("xor_flags", flags, 4'b0100);

        // bounce then long hold
        press(8'h00, 8);
        check("pre_bounce_state", st, 0);
        @(negedge clk); btn_next = 1'b1;
        repeat (2) @(negedge clk); btn_next = 1'b0;
        @(negedge clk);            btn_next = 1'b1;
        repeat (2) @(negedge clk); btn_next = 1'b0;
        repeat (15) @(negedge clk);
        check("bounce_state", st, 0);
        press(8'd5, 50);
        check("hold_state", st, 1);

        // clear handling
        press(8'd4, 8); press(8'h20, 8);
        check("pre_clr_led", led, 9);
        press(8'h00, 8); press(8'd1, 8); press(8'd2, 8);
        check("pre_clr_state", st, 2);
        press_clr(1'b0);
        check("clr_state", st, 0); check("clr_led", led, 0);
        press(8'd9, 8);
        press_clr(1'b1);
        check("clr_wins_state", st, 0);
        do_op(8'd1, 8'd2, 8'h3F);
        check("inv_led", led, 0); check("inv_err", err, 1); check("inv_flags", flags, 0);

        // async reset while a press is mid-debounce
        press(8'h00, 8); press(8'd5, 8);
        @(negedge clk); btn_next = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_state", st, 0); check("async_rst_err", err, 0);
        btn_next = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // random operations, with occasional clears
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 8)];
            if (op == 8'h00) op = 8'($urandom_range(0, 63));
            do_op(8'($urandom), 8'($urandom), op);
            if ($urandom_range(0, 7) == 0) press_clr(1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
